// File: rtl/hazard_pkg.sv
// Shared FSM encoding, default parameters and counter sizing for the hazard control unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    BR_WAIT    = 2'd2,
    MEM_WAIT   = 2'd3
  } hz_state_t;

  localparam int DEF_REG_AW   = 5;
  localparam int DEF_NUM_SRC  = 2;
  localparam int DEF_LOAD_LAT = 1;
  localparam int DEF_BR_DEPTH = 2;
  localparam int DEF_PERF_W   = 16;

  // Wide enough to hold the longest stall length; at least one bit.
  function automatic int cnt_width(int load_lat, int br_depth);
    int m;
    m = (load_lat > br_depth) ? load_lat : br_depth;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// One source-operand comparator: hits when a valid, non-zero source equals the load destination.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_valid,
  input  logic [REG_AW-1:0] rd,
  output logic              hit
);

  assign hit = rs_valid && (rs == rd) && (rd != '0);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stall, branch flush window, memory wait hold.
// Outputs react combinationally in the hazard cycle; mem_busy overrides and freezes all sequencing.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = DEF_REG_AW,
  parameter int NUM_SRC  = DEF_NUM_SRC,
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int BR_DEPTH = DEF_BR_DEPTH,
  parameter int PERF_W   = DEF_PERF_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      memRead_ID_EX,
  input  logic [REG_AW-1:0]         rd_ID_EX,
  input  logic [NUM_SRC*REG_AW-1:0] rs_IF_ID,
  input  logic [NUM_SRC-1:0]        rs_valid_IF_ID,
  input  logic                      branch_IF_ID,
  input  logic                      mem_busy,
  output logic                      stall_PC,
  output logic                      stall_IF_ID,
  output logic                      flush_IF_ID,
  output logic                      flush_ID_EX,
  output logic                      stall_ID_EX,
  output logic [1:0]                hazard_state,
  output logic [PERF_W-1:0]         stall_cycles
);

  localparam int CNT_W = cnt_width(LOAD_LAT, BR_DEPTH);

  hz_state_t        state, state_n, saved, saved_n, eff;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NUM_SRC-1:0] src_hit;
  logic             lu_hit;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    hazard_src_match #(.REG_AW(REG_AW)) u_match (
      .rs       (rs_IF_ID[k*REG_AW +: REG_AW]),
      .rs_valid (rs_valid_IF_ID[k]),
      .rd       (rd_ID_EX),
      .hit      (src_hit[k])
    );
  end

  assign lu_hit = memRead_ID_EX && (|src_hit) && (LOAD_LAT > 0);

  always_comb begin
    stall_PC    = 1'b0;
    stall_IF_ID = 1'b0;
    flush_IF_ID = 1'b0;
    flush_ID_EX = 1'b0;
    stall_ID_EX = 1'b0;
    state_n     = state;
    saved_n     = saved;
    cnt_n       = cnt;
    eff         = state;

    if (mem_busy) begin
      stall_PC    = 1'b1;
      stall_IF_ID = 1'b1;
      stall_ID_EX = 1'b1;
      state_n     = MEM_WAIT;
      if (state != MEM_WAIT) saved_n = state;
    end else begin
      // Leaving a memory wait behaves exactly like the interrupted state.
      if (state == MEM_WAIT) begin
        eff     = saved;
        state_n = saved;
      end
      case (eff)
        IDLE: begin
          if (lu_hit) begin
            stall_PC    = 1'b1;
            stall_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
            if (LOAD_LAT > 1) begin
              cnt_n   = CNT_W'(LOAD_LAT - 1);
              state_n = LOAD_STALL;
            end
          end else if (branch_IF_ID) begin
            stall_PC    = 1'b1;
            flush_IF_ID = 1'b1;
            if (BR_DEPTH > 1) begin
              cnt_n   = CNT_W'(BR_DEPTH - 1);
              state_n = BR_WAIT;
            end
          end
        end
        LOAD_STALL: begin
          stall_PC    = 1'b1;
          stall_IF_ID = 1'b1;
          flush_ID_EX = 1'b1;
          if (cnt != '0) cnt_n = cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) state_n = IDLE;
        end
        BR_WAIT: begin
          stall_PC    = 1'b1;
          flush_IF_ID = 1'b1;
          if (cnt != '0) cnt_n = cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end

    if (!reset) begin
      stall_PC    = 1'b0;
      stall_IF_ID = 1'b0;
      flush_IF_ID = 1'b0;
      flush_ID_EX = 1'b0;
      stall_ID_EX = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      saved        <= IDLE;
      cnt          <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_n;
      saved <= saved_n;
      cnt   <= cnt_n;
      if (stall_PC && (stall_cycles != '1)) stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

  assign hazard_state = state;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed scoreboard bench: dut A (LOAD_LAT=2, BR_DEPTH=3) and dut B (LOAD_LAT=1, BR_DEPTH=3, PERF_W=2).
module tb_hazard_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst = 1'b0, a_mr = 1'b0, a_br = 1'b0, a_mb = 1'b0;
  logic [4:0] a_rd = '0;
  logic [9:0] a_rs = '0;
  logic [1:0] a_v  = '0;
  logic       a_spc, a_sif, a_fif, a_fex, a_sex;
  logic [1:0] a_hs;
  logic [15:0] a_sc;

  logic       b_rst = 1'b0, b_mr = 1'b0, b_br = 1'b0, b_mb = 1'b0;
  logic [4:0] b_rd = '0;
  logic [9:0] b_rs = '0;
  logic [1:0] b_v  = '0;
  logic       b_spc, b_sif, b_fif, b_fex, b_sex;
  logic [1:0] b_hs;
  logic [1:0] b_sc;

  hazard_control_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(2), .BR_DEPTH(3), .PERF_W(16)) u_dut_a (
    .clk(clk), .reset(a_rst), .memRead_ID_EX(a_mr), .rd_ID_EX(a_rd), .rs_IF_ID(a_rs),
    .rs_valid_IF_ID(a_v), .branch_IF_ID(a_br), .mem_busy(a_mb),
    .stall_PC(a_spc), .stall_IF_ID(a_sif), .flush_IF_ID(a_fif), .flush_ID_EX(a_fex),
    .stall_ID_EX(a_sex), .hazard_state(a_hs), .stall_cycles(a_sc)
  );

  hazard_control_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .BR_DEPTH(3), .PERF_W(2)) u_dut_b (
    .clk(clk), .reset(b_rst), .memRead_ID_EX(b_mr), .rd_ID_EX(b_rd), .rs_IF_ID(b_rs),
    .rs_valid_IF_ID(b_v), .branch_IF_ID(b_br), .mem_busy(b_mb),
    .stall_PC(b_spc), .stall_IF_ID(b_sif), .flush_IF_ID(b_fif), .flush_ID_EX(b_fex),
    .stall_ID_EX(b_sex), .hazard_state(b_hs), .stall_cycles(b_sc)
  );

  // Output vector order: {stall_PC, stall_IF_ID, flush_IF_ID, flush_ID_EX, stall_ID_EX}
  localparam logic [4:0] O_NO  = 5'b00000;
  localparam logic [4:0] O_LD  = 5'b11010;
  localparam logic [4:0] O_BR  = 5'b10100;
  localparam logic [4:0] O_MEM = 5'b11001;

  typedef struct packed {
    logic        sel;
    logic [4:0]  o;
    logic [1:0]  st;
    logic [15:0] sc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  task automatic cyc(input bit sel, input logic rst, input logic mr, input logic [4:0] rd,
                     input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] v,
                     input logic br, input logic mb, input logic [4:0] eo,
                     input logic [1:0] es, input logic [15:0] esc, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    if (!sel) begin
      a_rst = rst; a_mr = mr; a_rd = rd; a_rs = {rs1, rs0}; a_v = v; a_br = br; a_mb = mb;
      b_mr = 1'b0; b_rd = '0; b_rs = '0; b_v = '0; b_br = 1'b0; b_mb = 1'b0;
    end else begin
      b_rst = rst; b_mr = mr; b_rd = rd; b_rs = {rs1, rs0}; b_v = v; b_br = br; b_mb = mb;
      a_mr = 1'b0; a_rd = '0; a_rs = '0; a_v = '0; a_br = 1'b0; a_mb = 1'b0;
    end
    e.sel = sel; e.o = eo; e.st = es; e.sc = esc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compares whichever DUT the queued expectation names, mid-cycle.
  always @(negedge clk) begin
    exp_t        e;
    string       nm;
    logic [4:0]  ao;
    logic [1:0]  ast;
    logic [15:0] asc;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (!e.sel) begin
        ao = {a_spc, a_sif, a_fif, a_fex, a_sex}; ast = a_hs; asc = a_sc;
      end else begin
        ao = {b_spc, b_sif, b_fif, b_fex, b_sex}; ast = b_hs; asc = {14'd0, b_sc};
      end
      checks++;
      if (ao !== e.o) begin
        failures++;
        $display("FAIL %s: got out=%b, expected out=%b", nm, ao, e.o);
      end
      checks++;
      if (ast !== e.st) begin
        failures++;
        $display("FAIL %s: got state=%0d, expected state=%0d", nm, ast, e.st);
      end
      checks++;
      if (asc !== e.sc) begin
        failures++;
        $display("FAIL %s: got cycles=%0d, expected cycles=%0d", nm, asc, e.sc);
      end
    end
  end

  initial begin
    // sel rst mr rd rs0 rs1 v br mb | out state cycles
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, O_NO, 0, 0, "a_reset_idle");
    cyc(0, 0, 1, 5, 0, 5, 2'b10, 1, 1, O_NO, 0, 0, "a_reset_masks_hazard");
    cyc(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, O_NO, 0, 0, "a_idle_no_event");
    // load-use on slot 1, LOAD_LAT=2
    cyc(0, 1, 1, 5, 0, 5, 2'b10, 0, 0, O_LD, 0, 0, "a_lu_cycle1");
    cyc(0, 1, 1, 5, 0, 5, 2'b10, 0, 0, O_LD, 1, 1, "a_lu_cycle2");
    cyc(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, O_NO, 0, 2, "a_lu_done");
    // register 0 / invalid slot / no load
    cyc(0, 1, 1, 0, 0, 0, 2'b01, 0, 0, O_NO, 0, 2, "a_rd_zero");
    cyc(0, 1, 1, 7, 7, 3, 2'b10, 0, 0, O_NO, 0, 2, "a_invalid_slot");
    cyc(0, 1, 0, 9, 9, 0, 2'b01, 0, 0, O_NO, 0, 2, "a_no_memread");
    // branch pulse, BR_DEPTH=3
    cyc(0, 1, 0, 0, 0, 0, 2'b00, 1, 0, O_BR, 0, 2, "a_br_cycle1");
    cyc(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, O_BR, 2, 3, "a_br_cycle2");
    cyc(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, O_BR, 2, 4, "a_br_cycle3");
    cyc(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, O_NO, 0, 5, "a_br_done");
    // mem_busy 4 cycles inside BR_WAIT
    cyc(0, 1, 0, 0, 0, 0, 2'b00, 1, 0, O_BR,  0, 5,  "a_brm_cycle1");
    cyc(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, O_BR,  2, 6,  "a_brm_cycle2");
    cyc(0, 1, 0, 0, 0, 0, 2'b00, 0, 1, O_MEM, 2, 7,  "a_mem_1");
    cyc(0, 1, 0, 0, 0, 0, 2'b00, 0, 1, O_MEM, 3, 8,  "a_mem_2");
    cyc(0, 1, 0, 0, 0, 0, 2'b00, 0, 1, O_MEM, 3, 9,  "a_mem_3");
    cyc(0, 1, 0, 0, 0, 0, 2'b00, 0, 1, O_MEM, 3, 10, "a_mem_4");
    cyc(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, O_BR,  3, 11, "a_brm_resume");
    cyc(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, O_NO,  0, 12, "a_brm_done");
    // mem_busy beats load-use, then reset mid-LOAD_STALL
    cyc(0, 1, 1, 6, 6, 0, 2'b01, 0, 1, O_MEM, 0, 12, "a_mem_over_lu");
    cyc(0, 1, 1, 6, 6, 0, 2'b01, 0, 0, O_LD,  3, 13, "a_lu_after_mem");
    cyc(0, 0, 1, 6, 6, 0, 2'b01, 0, 0, O_NO,  1, 14, "a_reset_mid_stall");
    cyc(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, O_NO,  0, 0,  "a_after_reset");
    // dut B: coincident load-use + held branch, LOAD_LAT=1, then saturation at PERF_W=2
    cyc(1, 1, 1, 5, 0, 5, 2'b10, 1, 0, O_LD, 0, 0, "b_lu_first");
    cyc(1, 1, 0, 0, 0, 0, 2'b00, 1, 0, O_BR, 0, 1, "b_br_cycle1");
    cyc(1, 1, 0, 0, 0, 0, 2'b00, 1, 0, O_BR, 2, 2, "b_br_cycle2");
    cyc(1, 1, 0, 0, 0, 0, 2'b00, 1, 0, O_BR, 2, 3, "b_br_cycle3");
    cyc(1, 1, 0, 0, 0, 0, 2'b00, 0, 0, O_NO, 0, 3, "b_sat_idle");
    cyc(1, 1, 1, 4, 4, 0, 2'b01, 0, 0, O_LD, 0, 3, "b_fifth_stall");
    cyc(1, 1, 0, 0, 0, 0, 2'b00, 0, 0, O_NO, 0, 3, "b_sat_hold");
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
